// File: rtl/ultrasonic_echo_emulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_pkg
// Purpose  : Shared states, defaults and helpers for the ultrasonic trig/echo link.
// Revision : 1.0 - initial release
// ============================================================================
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        DELAY   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    localparam int c_MIN_TRIG_US_DEFAULT = 10;
    localparam int c_MAX_ECHO_US_DEFAULT = 38000;

    function automatic int us_from_mclk(input int mclk_hz);
        return mclk_hz / 1000000;
    endfunction

endpackage : ultrasonic_pkg
`default_nettype wire

// File: rtl/ultrasonic_echo_emulator_if.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_echo_emulator_if
// Purpose  : Trig/echo bundle between an ultrasonic controller and the emulator.
// Revision : 1.0 - initial release
// ============================================================================
interface ultrasonic_echo_emulator_if;
    logic        en;
    logic        trig;
    logic [15:0] echo_us;
    logic        target_present;
    logic        echo;
    logic        busy;
    logic        trig_err;
    logic        meas_done;
    logic [15:0] echo_cnt;

    modport master (
        output en, trig, echo_us, target_present,
        input  echo, busy, trig_err, meas_done, echo_cnt
    );

    modport slave (
        input  en, trig, echo_us, target_present,
        output echo, busy, trig_err, meas_done, echo_cnt
    );
endinterface : ultrasonic_echo_emulator_if
`default_nettype wire

// File: rtl/us_duration_timer.sv
`default_nettype none
// ============================================================================
// Module   : us_duration_timer
// Purpose  : Loadable 32-bit cycle down-counter with done flag and saturating up mode.
// Revision : 1.0 - initial release
// ============================================================================
module us_duration_timer (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_load,
    input  wire logic [31:0] i_load_val,
    input  wire logic        i_inc,
    input  wire logic        i_dec,
    output logic      [31:0] o_count,
    output logic             o_done
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
        end else if (i_dec) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 32'd1;
        end
    end

    // A value of 1 marks the last cycle of a loaded interval.
    assign o_done  = (r_cnt <= 32'd1);
    assign o_count = r_cnt;

endmodule : us_duration_timer
`default_nettype wire

// File: rtl/ultrasonic_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_echo_emulator
// Purpose  : HC-SR04-style responder: answers a trig pulse with a programmed echo width.
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_echo_emulator
    import ultrasonic_pkg::*;
#(
    parameter int MCLK          = 100000000,
    parameter int US            = us_from_mclk(MCLK),
    parameter int MIN_TRIG_US   = c_MIN_TRIG_US_DEFAULT,
    parameter int ECHO_DELAY_US = 200,
    parameter int MAX_ECHO_US   = c_MAX_ECHO_US_DEFAULT,
    parameter int HOLDOFF_US    = 1000
) (
    input  wire logic                 mclk,
    input  wire logic                 rst,
    ultrasonic_echo_emulator_if.slave bus
);

    localparam longint c_MAX_CYC_64  = longint'(MAX_ECHO_US) * longint'(US);
    localparam logic [31:0] c_MIN_TRIG_CYC = 32'(longint'(MIN_TRIG_US) * longint'(US));
    localparam logic [31:0] c_DELAY_CYC    = 32'(longint'(ECHO_DELAY_US) * longint'(US));
    localparam logic [31:0] c_HOLD_CYC     = 32'(longint'(HOLDOFF_US) * longint'(US));
    localparam logic [31:0] c_US_32        = 32'(US);
    localparam logic [15:0] c_MAX_ECHO_16  = 16'(MAX_ECHO_US);

    if (US < 1) begin : g_bad_us
        $error("US must be at least 1");
    end
    if (MAX_ECHO_US < 1 || MAX_ECHO_US > 65535) begin : g_bad_max_echo
        $error("MAX_ECHO_US must be in 1..65535");
    end
    if (c_MAX_CYC_64 > 64'sh0000_0000_FFFF_FFFF) begin : g_bad_max_cycles
        $error("MAX_ECHO_US*US does not fit in 32 bits");
    end
    if (ECHO_DELAY_US < 1 || HOLDOFF_US < 1) begin : g_bad_intervals
        $error("ECHO_DELAY_US and HOLDOFF_US must be at least 1");
    end

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1, r_sync2, r_sync3;
    logic        w_rise, w_fall;
    logic [15:0] r_width;
    logic [15:0] w_width_sel;
    logic        r_echo, r_busy, r_trig_err, r_meas_done;
    logic [15:0] r_echo_cnt;
    logic        w_latch, w_err, w_echo_end;
    logic        w_load, w_inc, w_dec;
    logic [31:0] w_load_val;
    logic [31:0] w_count;
    logic        w_done;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= bus.trig;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync3;
    assign w_fall = ~r_sync2 & r_sync3;

    // Absent targets, zero requests and out-of-range requests all report the maximum range.
    assign w_width_sel = (!bus.target_present || (bus.echo_us == 16'd0) ||
                          ({16'd0, bus.echo_us} > 32'(MAX_ECHO_US)))
                         ? c_MAX_ECHO_16 : bus.echo_us;

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_err      = 1'b0;
        w_echo_end = 1'b0;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        if (!bus.en) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) w_next = TRIG_HI;
                end
                TRIG_HI: begin
                    if (w_fall) begin
                        if (w_count >= c_MIN_TRIG_CYC) begin
                            w_next  = DELAY;
                            w_latch = 1'b1;
                        end else begin
                            w_next = IDLE;
                            w_err  = 1'b1;
                        end
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                DELAY: begin
                    if (w_done) w_next = ECHO;
                    else        w_dec  = 1'b1;
                end
                ECHO: begin
                    if (w_done) begin
                        w_next     = HOLDOFF;
                        w_echo_end = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (w_done) w_next = IDLE;
                    else        w_dec  = 1'b1;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Every state entry reloads the shared timer with the interval of the new state.
    always_comb begin
        w_load     = (w_next != r_state);
        w_load_val = 32'd0;
        case (w_next)
            TRIG_HI: w_load_val = 32'd1;
            DELAY:   w_load_val = c_DELAY_CYC;
            ECHO:    w_load_val = {16'd0, r_width} * c_US_32;
            HOLDOFF: w_load_val = c_HOLD_CYC;
            default: w_load_val = 32'd0;
        endcase
    end

    us_duration_timer u_timer (
        .clk        (mclk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_inc      (w_inc),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_done     (w_done)
    );

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_width     <= '0;
            r_echo      <= 1'b0;
            r_busy      <= 1'b0;
            r_trig_err  <= 1'b0;
            r_meas_done <= 1'b0;
            r_echo_cnt  <= '0;
        end else begin
            r_state     <= w_next;
            r_echo      <= (w_next == ECHO);
            r_busy      <= (r_state != IDLE);
            r_trig_err  <= w_err;
            r_meas_done <= w_echo_end;
            if (w_latch)    r_width    <= w_width_sel;
            if (w_echo_end) r_echo_cnt <= r_echo_cnt + 16'd1;
        end
    end

    assign bus.echo      = r_echo;
    assign bus.busy      = r_busy;
    assign bus.trig_err  = r_trig_err;
    assign bus.meas_done = r_meas_done;
    assign bus.echo_cnt  = r_echo_cnt;

endmodule : ultrasonic_echo_emulator
`default_nettype wire

// File: tb/tb_ultrasonic_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_echo_emulator
// Purpose  : Scoreboard bench for the ultrasonic echo emulator, scaled to US=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_echo_emulator;

    localparam int P_MCLK    = 2000000;
    localparam int P_US      = 2;
    localparam int P_MIN_US  = 10;
    localparam int P_DLY_US  = 20;
    localparam int P_MAX_US  = 300;
    localparam int P_HOLD_US = 50;
    localparam int D_CYC     = P_DLY_US * P_US;
    localparam int MAX_CYC   = P_MAX_US * P_US;

    typedef struct {
        int   width;
        logic meas;
    } exp_t;

    logic mclk = 1'b0;
    logic rst  = 1'b1;

    ultrasonic_echo_emulator_if u_if ();

    ultrasonic_echo_emulator #(
        .MCLK          (P_MCLK),
        .MIN_TRIG_US   (P_MIN_US),
        .ECHO_DELAY_US (P_DLY_US),
        .MAX_ECHO_US   (P_MAX_US),
        .HOLDOFF_US    (P_HOLD_US)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (u_if.slave)
    );

    always #5 mclk = ~mclk;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    exp_t        e_mon;
    int          echo_len    = 0;
    logic        echo_prev   = 1'b0;
    int          rises       = 0;
    int          meas_pulses = 0;
    int          err_pulses  = 0;
    logic [15:0] exp_cnt     = 16'd0;

    // Monitor: measures each echo pulse and retires it against the scoreboard.
    always @(negedge mclk) begin
        if (u_if.meas_done) meas_pulses++;
        if (u_if.trig_err)  err_pulses++;
        if (u_if.echo) begin
            if (!echo_prev) rises++;
            echo_len++;
        end else if (echo_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL echo_unexpected width=%0d required=no pulse", echo_len);
            end else begin
                e_mon = exp_q.pop_front();
                if (echo_len !== e_mon.width) begin
                    failures++;
                    $display("FAIL echo_width got=%0d required=%0d", echo_len, e_mon.width);
                end
                checks++;
                if (u_if.meas_done !== e_mon.meas) begin
                    failures++;
                    $display("FAIL meas_at_fall got=%b required=%b", u_if.meas_done, e_mon.meas);
                end
            end
            echo_len = 0;
        end
        echo_prev = u_if.echo;
    end

    task automatic do_trig(input int hi_cycles);
        @(negedge mclk);
        u_if.trig = 1'b1;
        repeat (hi_cycles) @(negedge mclk);
        u_if.trig = 1'b0;
    endtask

    task automatic wait_busy_low(input int max_cycles, input string tag);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            @(negedge mclk);
            if (!u_if.busy) break;
        end
        if (i == max_cycles) begin
            checks++;
            failures++;
            $display("FAIL %s busy_timeout got=busy required=idle within %0d", tag, max_cycles);
        end
    endtask

    task automatic wait_echo_high(input int max_cycles, input string tag);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            @(negedge mclk);
            if (u_if.echo) break;
        end
        if (i == max_cycles) begin
            checks++;
            failures++;
            $display("FAIL %s echo_timeout got=low required=high within %0d", tag, max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.en = 1'b1;
        u_if.trig = 1'b0;
        u_if.echo_us = 16'd0;
        u_if.target_present = 1'b1;
        repeat (3) @(negedge mclk);
        checks++; if (u_if.echo !== 1'b0)      begin failures++; $display("FAIL reset_echo got=%b required=0", u_if.echo); end
        checks++; if (u_if.busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b required=0", u_if.busy); end
        checks++; if (u_if.trig_err !== 1'b0)  begin failures++; $display("FAIL reset_trig_err got=%b required=0", u_if.trig_err); end
        checks++; if (u_if.meas_done !== 1'b0) begin failures++; $display("FAIL reset_meas got=%b required=0", u_if.meas_done); end
        checks++; if (u_if.echo_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d required=0", u_if.echo_cnt); end
        rst = 1'b0;
        repeat (2) @(negedge mclk);
    endtask

    task automatic test_basic();
        int m0;
        m0 = meas_pulses;
        u_if.echo_us = 16'd25;
        exp_q.push_back('{width: 25 * P_US, meas: 1'b1});
        do_trig(P_MIN_US * P_US);
        // 2 synchroniser flops, 1 state register, then the delay interval.
        repeat (D_CYC + 2) @(negedge mclk);
        checks++; if (u_if.echo !== 1'b0) begin failures++; $display("FAIL basic_early_echo got=%b required=0", u_if.echo); end
        checks++; if (u_if.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b required=1", u_if.busy); end
        @(negedge mclk);
        checks++; if (u_if.echo !== 1'b1) begin failures++; $display("FAIL basic_echo_rise got=%b required=1", u_if.echo); end
        wait_busy_low(2000, "basic");
        exp_cnt++;
        checks++; if (u_if.echo_cnt !== exp_cnt) begin failures++; $display("FAIL basic_cnt got=%0d required=%0d", u_if.echo_cnt, exp_cnt); end
        checks++; if (meas_pulses - m0 !== 1) begin failures++; $display("FAIL basic_meas_pulses got=%0d required=1", meas_pulses - m0); end
    endtask

    task automatic test_short_trig();
        int e0, r0;
        e0 = err_pulses;
        r0 = rises;
        do_trig(P_MIN_US * P_US - 2);
        repeat (D_CYC + 20) @(negedge mclk);
        checks++; if (err_pulses - e0 !== 1) begin failures++; $display("FAIL short_err_pulses got=%0d required=1", err_pulses - e0); end
        checks++; if (rises - r0 !== 0)      begin failures++; $display("FAIL short_echo_rises got=%0d required=0", rises - r0); end
        checks++; if (u_if.busy !== 1'b0)    begin failures++; $display("FAIL short_busy got=%b required=0", u_if.busy); end
        checks++; if (u_if.echo_cnt !== exp_cnt) begin failures++; $display("FAIL short_cnt got=%0d required=%0d", u_if.echo_cnt, exp_cnt); end
    endtask

    task automatic test_width_select();
        logic [15:0] req[5]  = '{16'd25, 16'd400, 16'd300, 16'd0, 16'd1};
        logic        tp[5]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int          wexp[5] = '{MAX_CYC, MAX_CYC, MAX_CYC, MAX_CYC, P_US};
        for (int k = 0; k < 5; k++) begin
            u_if.echo_us = req[k];
            u_if.target_present = tp[k];
            exp_q.push_back('{width: wexp[k], meas: 1'b1});
            do_trig(P_MIN_US * P_US);
            wait_busy_low(3000, "width");
            exp_cnt++;
            checks++;
            if (u_if.echo_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL width_cnt case=%0d got=%0d required=%0d", k, u_if.echo_cnt, exp_cnt);
            end
        end
        u_if.target_present = 1'b1;
    endtask

    task automatic test_ignore_retrigger();
        int r0, m0, i;
        r0 = rises;
        m0 = meas_pulses;
        u_if.echo_us = 16'd30;
        exp_q.push_back('{width: 30 * P_US, meas: 1'b1});
        do_trig(P_MIN_US * P_US);
        wait_echo_high(200, "ignore");
        repeat (5) @(negedge mclk);
        do_trig(P_MIN_US * P_US);
        for (i = 0; i < 500; i++) begin
            @(negedge mclk);
            if (meas_pulses != m0) break;
        end
        if (i == 500) begin
            checks++; failures++;
            $display("FAIL ignore_meas_timeout got=none required=pulse");
        end
        exp_cnt++;
        repeat (5) @(negedge mclk);
        do_trig(P_MIN_US * P_US);
        repeat (10) @(negedge mclk);
        u_if.trig = 1'b1;
        repeat (150) @(negedge mclk);
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL level_busy got=%b required=0", u_if.busy); end
        checks++; if (rises - r0 !== 1)   begin failures++; $display("FAIL ignore_rises got=%0d required=1", rises - r0); end
        u_if.trig = 1'b0;
        repeat (10) @(negedge mclk);
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL level_release_busy got=%b required=0", u_if.busy); end
        checks++; if (u_if.echo_cnt !== exp_cnt) begin failures++; $display("FAIL ignore_cnt got=%0d required=%0d", u_if.echo_cnt, exp_cnt); end
        exp_q.push_back('{width: 30 * P_US, meas: 1'b1});
        do_trig(P_MIN_US * P_US);
        wait_busy_low(2000, "clean");
        exp_cnt++;
        checks++; if (u_if.echo_cnt !== exp_cnt) begin failures++; $display("FAIL clean_cnt got=%0d required=%0d", u_if.echo_cnt, exp_cnt); end
        checks++; if (rises - r0 !== 2)          begin failures++; $display("FAIL clean_rises got=%0d required=2", rises - r0); end
    endtask

    task automatic test_abort();
        int m0;
        m0 = meas_pulses;
        u_if.echo_us = 16'd100;
        do_trig(P_MIN_US * P_US);
        wait_echo_high(200, "abort");
        repeat (30) @(negedge mclk);
        exp_q.push_back('{width: 31, meas: 1'b0});
        u_if.en = 1'b0;
        @(negedge mclk);
        checks++; if (u_if.echo !== 1'b0) begin failures++; $display("FAIL abort_echo got=%b required=0", u_if.echo); end
        @(negedge mclk);
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b required=0", u_if.busy); end
        u_if.en = 1'b1;
        repeat (300) @(negedge mclk);
        checks++; if (u_if.echo_cnt !== exp_cnt) begin failures++; $display("FAIL abort_cnt got=%0d required=%0d", u_if.echo_cnt, exp_cnt); end
        checks++; if (meas_pulses - m0 !== 0)    begin failures++; $display("FAIL abort_meas got=%0d required=0", meas_pulses - m0); end
        // Asynchronous reset in the middle of DELAY.
        do_trig(P_MIN_US * P_US);
        repeat (D_CYC / 2) @(negedge mclk);
        checks++; if (u_if.busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b required=1", u_if.busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (u_if.busy !== 1'b0)      begin failures++; $display("FAIL async_rst_busy got=%b required=0", u_if.busy); end
        checks++; if (u_if.echo_cnt !== 16'd0) begin failures++; $display("FAIL async_rst_cnt got=%0d required=0", u_if.echo_cnt); end
        checks++; if (u_if.echo !== 1'b0)      begin failures++; $display("FAIL async_rst_echo got=%b required=0", u_if.echo); end
        exp_cnt = 16'd0;
        @(negedge mclk);
        rst = 1'b0;
        repeat (D_CYC + 20) @(negedge mclk);
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%b required=0", u_if.busy); end
    endtask

    task automatic test_wrap();
        @(negedge mclk);
        force dut.r_echo_cnt = 16'hFFFF;
        @(negedge mclk);
        release dut.r_echo_cnt;
        exp_cnt = 16'hFFFF;
        checks++; if (u_if.echo_cnt !== exp_cnt) begin failures++; $display("FAIL wrap_preset got=%0d required=%0d", u_if.echo_cnt, exp_cnt); end
        u_if.echo_us = 16'd40;
        exp_q.push_back('{width: 40 * P_US, meas: 1'b1});
        do_trig(P_MIN_US * P_US);
        wait_echo_high(200, "wrap");
        repeat (10) @(negedge mclk);
        u_if.echo_us = 16'd5;
        wait_busy_low(2000, "wrap");
        exp_cnt++;
        checks++; if (u_if.echo_cnt !== exp_cnt) begin failures++; $display("FAIL wrap_cnt got=%0d required=%0d", u_if.echo_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_trig();
        test_width_select();
        test_ignore_retrigger();
        test_abort();
        test_wrap();
        repeat (5) @(negedge mclk);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ultrasonic_echo_emulator
`default_nettype wire

// File: doc/ultrasonic_echo_emulator.md
Name: ultrasonic_echo_emulator

Overview:
Emulates an HC-SR04-style ultrasonic sensor: it responds to a trig pulse with an echo pulse whose width encodes a programmed distance in microseconds. It is the responder end of the robot ultrasonic trig/echo interface. It is used in simulation and hardware-in-loop builds to drive the ultrasonic controller's echo input without a physical sensor. Distance is supplied by software or a testbench through echo_us and target_present.

Parameters:
MCLK, 100000000, mclk frequency in Hz
US, MCLK/1000000, mclk cycles per microsecond (must be >= 1)
MIN_TRIG_US, 10, minimum valid trig high width in us
ECHO_DELAY_US, 200, trig falling edge to echo rise, in us (burst time)
MAX_ECHO_US, 38000, echo width for no target or out-of-range request, in us
HOLDOFF_US, 1000, post-echo dead time in us; trig is ignored during it

Ports:
mclk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  block enable; low forces IDLE
trig  in  1  trigger from controller (asynchronous, synchronised internally)
echo_us  in  16  requested echo width in us, sampled at trig fall
target_present  in  1  0 = no object, emit MAX_ECHO_US
echo  out  1  echo pulse to controller (registered)
busy  out  1  high whenever state != IDLE
trig_err  out  1  1-cycle pulse: trig high width below MIN_TRIG_US
meas_done  out  1  1-cycle pulse on the cycle echo falls
echo_cnt  out  16  completed echo pulses, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst=1): state IDLE; echo=0, busy=0, trig_err=0, meas_done=0, echo_cnt=0; synchroniser and counters cleared.
- trig passes a 2-flop synchroniser (trig_s). Edges are detected on trig_s against a third flop. Latency is 2 mclk from trig to trig_s.
- Single cycle counter (32 bit) is loaded/cleared on every state entry. All durations are exact mclk counts: N us = N*US cycles.
- IDLE: on trig_s rise -> TRIG_HI; counter=1 on entry.
- TRIG_HI: counter increments (saturating) while trig_s=1. On trig_s fall:
  - If count >= MIN_TRIG_US*US: latch width W and go to DELAY.
    - W = MAX_ECHO_US if target_present=0, echo_us=0, or echo_us>MAX_ECHO_US; otherwise W = echo_us.
  - Otherwise pulse trig_err and go to IDLE.
- DELAY: wait ECHO_DELAY_US*US cycles -> ECHO. echo rises on the first ECHO cycle.
- ECHO: echo=1 for exactly W*US cycles. The falling cycle pulses meas_done, increments echo_cnt, and goes to HOLDOFF.
- HOLDOFF: wait HOLDOFF_US*US cycles -> IDLE. If trig_s is high on exit, a rise is not seen until trig_s returns low; no retrigger on a level.
- trig edges in DELAY, ECHO and HOLDOFF are ignored. echo_us changes after the latch have no effect on the current pulse.
- en=0 in any state: next cycle state=IDLE, echo=0, no meas_done, no echo_cnt increment. echo_cnt is preserved.
- en=0 and a trig_s fall in the same cycle: en wins.
- busy is registered from state; it rises the cycle after TRIG_HI entry.
- Width arithmetic: the W*US product is computed in 32 bits. MAX_ECHO_US*US must fit in 32 bits (elaboration check).

Decomposition:
- Shared package ultrasonic_pkg holds:
  - state enum IDLE/TRIG_HI/DELAY/ECHO/HOLDOFF
  - US derivation
  - default MAX_ECHO_US/MIN_TRIG_US constants, also used by the controller
- One natural sub-module, us_duration_timer: loadable down-counter in cycles with a load strobe, a done flag and a saturating up-count mode. It is instantiated once and shared across states.

Test Plan:
1. US=100; trig high 10 us (1000 cycles), echo_us=580, target_present=1 -> echo rises 200 us (20000 cycles, +2 sync) after trig fall, is high exactly 58000 cycles, meas_done pulses once, echo_cnt=1.
2. trig high 9 us (900 cycles) -> trig_err single pulse, echo stays 0, busy returns 0, echo_cnt unchanged.
3. target_present=0, and separately echo_us=40000 -> echo width 38000 us (3800000 cycles) in both cases.
4. Second trig during ECHO and during HOLDOFF -> ignored. Trig held high across HOLDOFF exit -> no new measurement. The next clean trig after HOLDOFF produces a normal echo.
5. en deasserted mid-ECHO -> echo=0 the next cycle, state IDLE, echo_cnt unchanged. rst asserted mid-DELAY -> all outputs 0 immediately, with no clock edge needed.
6. echo_cnt preset via 65535 runs (or forced) -> the next completed echo wraps it to 0. echo_us changed mid-pulse -> the current width is unaffected.
